// File: rtl/input_debouncer_if.sv
// Button/switch bundle for the input debouncer.
// Raw levels go in; debounced levels and registered edge pulses come out.
interface input_debouncer_if #(
  parameter int NBTN = 5,
  parameter int NSW  = 16
);
  logic [NBTN-1:0] btn;
  logic [NSW-1:0]  sw;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NSW-1:0]  sw_level;
  logic            sw_changed;

  // Stimulus side: drives raw levels, observes debounced results.
  modport master (
    output btn, sw,
    input  btn_level, btn_press, btn_release, sw_level, sw_changed
  );

  // Debouncer side.
  modport slave (
    input  btn, sw,
    output btn_level, btn_press, btn_release, sw_level, sw_changed
  );
endinterface

// File: rtl/input_debouncer.sv
// Debouncer for NBTN buttons and NSW switches. Every input is an independent
// channel: 2-flop synchronizer, then a saturating stability counter that only
// lets a new level through after 2^LOG2DELAY consecutive differing samples.

// One debounce channel. 'load' is high in the cycle before 'level' flips,
// so the parent can register edge pulses that line up with the new level.
module debounce_chan #(
  parameter int LOG2DELAY = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic load
);
  localparam logic [LOG2DELAY-1:0] CNT_MAX = '1;

  logic                 sync1, sync2;
  logic [LOG2DELAY-1:0] cnt;

  // Window complete and the synchronized input still disagrees: take it.
  assign load = (sync2 != level) && (cnt == CNT_MAX);

  // Synchronizer, stability counter and debounced level. Any return of sync2
  // to the current level clears the counter, discarding a pending change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (load) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module input_debouncer #(
  parameter int LOG2DELAY = 16,
  parameter int NBTN      = 5,
  parameter int NSW       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input_debouncer_if.slave    bus
);
  logic [NBTN-1:0] btn_lvl, btn_ld;
  logic [NSW-1:0]  sw_lvl, sw_ld;
  logic [NBTN-1:0] press_q, release_q;
  logic            chg_q;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_chan #(.LOG2DELAY(LOG2DELAY)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn[i]),
      .level (btn_lvl[i]),
      .load  (btn_ld[i])
    );
  end

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    debounce_chan #(.LOG2DELAY(LOG2DELAY)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.sw[i]),
      .level (sw_lvl[i]),
      .load  (sw_ld[i])
    );
  end

  // Edge pulses registered on the same edge the level flips; a load always
  // inverts the level, so the old level tells the direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
      chg_q     <= 1'b0;
    end else begin
      press_q   <= btn_ld & ~btn_lvl;
      release_q <= btn_ld & btn_lvl;
      chg_q     <= |sw_ld;
    end
  end

  assign bus.btn_level   = btn_lvl;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.sw_level    = sw_lvl;
  assign bus.sw_changed  = chg_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer with a 16-cycle window (level moves 18 edges
// after the first sampling edge). Table vectors go through a scoreboard
// queue; exact-edge corner cases are hand-written sequences.
module tb_input_debouncer;
  localparam int L2D = 4;
  localparam int NB  = 5;
  localparam int NS  = 16;
  localparam int LAT = (1 << L2D) + 2;

  logic clk;
  logic rst_n;

  input_debouncer_if #(.NBTN(NB), .NSW(NS)) bus ();

  input_debouncer #(.LOG2DELAY(L2D), .NBTN(NB), .NSW(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [NB-1:0] btn_level;
    logic [NS-1:0] sw_level;
    int            press_n;
    int            rel_n;
    int            chg_n;
  } exp_t;

  typedef struct {
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    int            cycles;
    exp_t          e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   press_acc, rel_acc, chg_acc, overlap, b1_act;
  exp_t sbq[$];
  vec_t tbl[13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    press_acc += $countones(bus.btn_press);
    rel_acc   += $countones(bus.btn_release);
    chg_acc   += int'(bus.sw_changed);
    if ((bus.btn_press & bus.btn_release) != '0) overlap++;
    if (bus.btn_level[1] | bus.btn_press[1] | bus.btn_release[1]) b1_act++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_acc();
    press_acc = 0; rel_acc = 0; chg_acc = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    bus.btn = '0; bus.sw = '0;
    repeat (LAT + 6) @(negedge clk);
  endtask

  // Drive one vector at a falling edge, queue its expectation, hold, compare.
  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    bus.btn = v.btn;
    bus.sw  = v.sw;
    rst_n   = v.rst_n;
    sbq.push_back(v.e);
    clear_acc();
    if (!v.rst_n) begin
      #1;
      check($sformatf("v%0d_async_rst", idx), {11'd0, bus.btn_level, bus.sw_level}, 32'd0);
    end
    repeat (v.cycles) @(negedge clk);
    e = sbq.pop_front();
    check($sformatf("v%0d_btn_level", idx), {27'd0, bus.btn_level}, {27'd0, e.btn_level});
    check($sformatf("v%0d_sw_level", idx),  {16'd0, bus.sw_level},  {16'd0, e.sw_level});
    check($sformatf("v%0d_press_cnt", idx),   press_acc, e.press_n);
    check($sformatf("v%0d_release_cnt", idx), rel_acc,   e.rel_n);
    check($sformatf("v%0d_changed_cnt", idx), chg_acc,   e.chg_n);
  endtask

  initial begin
    press_acc = 0; rel_acc = 0; chg_acc = 0; overlap = 0; b1_act = 0;
    rst_n   = 1'b0;
    bus.btn = '0;
    bus.sw  = '0;

    tbl[0]  = '{1'b0, 5'h1F, 16'hFFFF, 3,  '{5'h00, 16'h0000, 0, 0, 0}};
    tbl[1]  = '{1'b1, 5'h00, 16'h0000, 25, '{5'h00, 16'h0000, 0, 0, 0}};
    tbl[2]  = '{1'b1, 5'h01, 16'h0000, 25, '{5'h01, 16'h0000, 1, 0, 0}};
    tbl[3]  = '{1'b1, 5'h00, 16'h0000, 25, '{5'h00, 16'h0000, 0, 1, 0}};
    tbl[4]  = '{1'b1, 5'h00, 16'hA5A5, 25, '{5'h00, 16'hA5A5, 0, 0, 1}};
    tbl[5]  = '{1'b1, 5'h1F, 16'h0000, 25, '{5'h1F, 16'h0000, 5, 0, 1}};
    tbl[6]  = '{1'b1, 5'h00, 16'hFFFF, 25, '{5'h00, 16'hFFFF, 0, 5, 1}};
    tbl[7]  = '{1'b1, 5'h0A, 16'h1234, 10, '{5'h00, 16'hFFFF, 0, 0, 0}};
    tbl[8]  = '{1'b1, 5'h0A, 16'h1234, 15, '{5'h0A, 16'h1234, 2, 0, 1}};
    tbl[9]  = '{1'b0, 5'h0A, 16'h1234, 2,  '{5'h00, 16'h0000, 0, 0, 0}};
    tbl[10] = '{1'b1, 5'h0A, 16'h1234, 25, '{5'h0A, 16'h1234, 2, 0, 1}};
    tbl[11] = '{1'b1, 5'h0B, 16'h1235, 5,  '{5'h0A, 16'h1234, 0, 0, 0}};
    tbl[12] = '{1'b1, 5'h0A, 16'h1234, 25, '{5'h0A, 16'h1234, 0, 0, 0}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.btn_level, bus.btn_press, bus.btn_release, bus.sw_level, bus.sw_changed},
          32'd0);
    rst_n = 1'b1;

    // btn[0] press/release with exact edge timing.
    @(negedge clk);
    bus.btn[0] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("press_lvl_e%0d", k), {31'd0, bus.btn_level[0]}, {31'd0, (k >= LAT)});
      check($sformatf("press_pls_e%0d", k), {31'd0, bus.btn_press[0]}, {31'd0, (k == LAT)});
    end
    @(negedge clk);
    bus.btn[0] = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("rel_lvl_e%0d", k), {31'd0, bus.btn_level[0]}, {31'd0, (k < LAT)});
      check($sformatf("rel_pls_e%0d", k), {31'd0, bus.btn_release[0]}, {31'd0, (k == LAT)});
    end

    // btn[1] bouncing every 5 cycles never completes a window.
    settle();
    b1_act = 0;
    for (int i = 0; i < 20; i++) begin
      bus.btn[1] = ~bus.btn[1];
      repeat (5) @(negedge clk);
    end
    bus.btn[1] = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    check("bounce_btn1_activity", b1_act, 0);

    // Reset mid-window restarts the debounce from scratch.
    settle();
    clear_acc();
    bus.btn[2] = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_async_level", {27'd0, bus.btn_level}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_level_in_rst", {31'd0, bus.btn_level[2]}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_lvl_e%0d", k), {31'd0, bus.btn_level[2]}, {31'd0, (k >= LAT)});
    end
    repeat (5) @(negedge clk);
    check("midrst_press_cnt", press_acc, 1);

    // One-cycle sw[3] glitch near the end of a btn[4] window.
    settle();
    clear_acc();
    bus.btn[4] = 1'b1;
    repeat (15) @(negedge clk);
    bus.sw[3] = 1'b1;
    @(negedge clk);
    bus.sw[3] = 1'b0;
    @(posedge clk); #1;
    check("glitch_btn4_e17", {31'd0, bus.btn_level[4]}, 32'd0);
    @(posedge clk); #1;
    check("glitch_btn4_e18", {31'd0, bus.btn_level[4]}, 32'd1);
    check("glitch_press4_e18", {31'd0, bus.btn_press[4]}, 32'd1);
    repeat (LAT + 6) @(negedge clk);
    check("glitch_sw_level", {16'd0, bus.sw_level}, 32'd0);
    check("glitch_sw_changed", chg_acc, 0);

    // Table vectors.
    @(negedge clk);
    for (int i = 0; i < 13; i++) apply_vec(tbl[i], i);

    check("press_release_overlap", overlap, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
